// File: rtl/axis_output_gearbox.sv
// Width gearbox from wide result words to an AXI-Stream beat stream.
// Input words queue in a small FIFO; each word is sent as RATIO beats, LSB lane first, with tlast framing.
module axis_output_gearbox #(
    parameter int IN_WIDTH   = 128,
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic [IN_WIDTH-1:0]           i_data,
    output logic                          o_in_ready,
    input  logic [31:0]                   cfg_frame_beats,
    output logic [OUT_WIDTH-1:0]          axis_out_tdata,
    output logic                          axis_out_tvalid,
    input  logic                          axis_out_tready,
    output logic                          axis_out_tlast,
    output logic                          o_overflow,
    output logic                          o_frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LW-1:0] LAST_LANE  = LW'(RATIO - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    logic [IN_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [AW:0]         level_reg;
    logic [IN_WIDTH-1:0] word_reg;
    logic [LW-1:0]       lane_reg;
    logic                tvalid_reg;
    logic [31:0]         cnt_reg;
    logic [31:0]         shadow_reg;
    logic                overflow_reg;
    logic                frame_done_reg;

    logic        fifo_full;
    logic        fifo_empty;
    logic        handshake;
    logic        last_lane;
    logic        push;
    logic        pop;
    logic [31:0] beats_eff;
    logic        tlast;

    assign fifo_full  = (level_reg == FULL_LEVEL);
    assign fifo_empty = (level_reg == '0);
    assign handshake  = tvalid_reg & axis_out_tready;
    assign last_lane  = (lane_reg == LAST_LANE);
    assign push       = i_valid & ~fifo_full & ~i_clear;
    // The stage refills when idle or when its last lane leaves this cycle.
    assign pop        = ~fifo_empty & ~i_clear & (~tvalid_reg | (handshake & last_lane));

    // At count 0 the frame length is still open, so the live config applies.
    assign beats_eff  = (cnt_reg == 32'd0) ? cfg_frame_beats : shadow_reg;
    assign tlast      = tvalid_reg & (beats_eff != 32'd0) & (cnt_reg == beats_eff - 32'd1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            word_reg       <= '0;
            lane_reg       <= '0;
            tvalid_reg     <= 1'b0;
            cnt_reg        <= '0;
            shadow_reg     <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else if (i_clear) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            word_reg       <= '0;
            lane_reg       <= '0;
            tvalid_reg     <= 1'b0;
            cnt_reg        <= '0;
            shadow_reg     <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_reg + (AW + 1)'(push) - (AW + 1)'(pop);

            if (i_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end
            frame_done_reg <= handshake & tlast;

            if (pop) begin
                word_reg   <= mem[rd_ptr_reg];
                lane_reg   <= '0;
                tvalid_reg <= 1'b1;
            end else if (handshake) begin
                if (last_lane) begin
                    tvalid_reg <= 1'b0;
                    lane_reg   <= '0;
                end else begin
                    lane_reg <= lane_reg + LW'(1);
                end
            end

            if (handshake) begin
                if (cnt_reg == 32'd0) begin
                    shadow_reg <= cfg_frame_beats;
                end
                if (beats_eff == 32'd0 || cnt_reg == beats_eff - 32'd1) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    end

    generate
        if (RATIO == 1) begin : g_single_lane
            assign axis_out_tdata = word_reg[OUT_WIDTH-1:0];
        end else begin : g_multi_lane
            assign axis_out_tdata = word_reg[lane_reg*OUT_WIDTH +: OUT_WIDTH];
        end
    endgenerate

    assign axis_out_tvalid = tvalid_reg;
    assign axis_out_tlast  = tlast;
    assign o_in_ready      = ~fifo_full;
    assign o_overflow      = overflow_reg;
    assign o_frame_done    = frame_done_reg;
    assign o_fifo_level    = level_reg;

endmodule
